mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, SHALL set data and address width.
REQ-002 Parameter MEM_LATENCY, default 2, range 1..15, SHALL set the number of cycles each memory access is held.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 i_req  in  1  instruction requester access request.
REQ-007 i_write  in  1  instruction access is a write (1) or a read (0).
REQ-008 i_address  in  WORD_SIZE  instruction access address.
REQ-009 i_wdata  in  WORD_SIZE  instruction write data.
REQ-010 i_rdata  out  WORD_SIZE  instruction read data, registered.
REQ-011 i_ack  out  1  one-cycle completion pulse for the instruction requester.
REQ-012 d_req, d_write, d_address, d_wdata, d_rdata, d_ack SHALL match REQ-006..011 for the data requester.
REQ-013 mem_readM  out  1  memory read strobe.
REQ-014 mem_writeM  out  1  memory write strobe.
REQ-015 mem_address  out  WORD_SIZE  memory address.
REQ-016 mem_wdata  out  WORD_SIZE  memory write data.
REQ-017 mem_rdata  in  WORD_SIZE  memory read data; valid after MEM_LATENCY cycles of mem_readM.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-020 IDLE: if any req is high at a clock edge, the arbiter SHALL grant one requester, latch its write, address and wdata, load the latency counter with MEM_LATENCY-1, and enter ACCESS.
REQ-021 Single requester: that requester SHALL be granted.
REQ-022 Both requesters high: the requester not granted last SHALL win (round-robin); a 1-bit last_grant register SHALL update on every grant.
REQ-023 ACCESS: mem_readM or mem_writeM SHALL be high per the latched write bit; mem_address and mem_wdata SHALL come from the latched values; the counter SHALL decrement each cycle; counter==0 SHALL move the FSM to RESP.
REQ-024 RESP, read: mem_readM SHALL stay high; mem_rdata SHALL be captured into the granted port's rdata at the end of the cycle.
REQ-025 RESP, write: both strobes SHALL be low.
REQ-026 RESP: the granted port's ack SHALL be high for exactly this cycle; the FSM SHALL then enter IDLE.
REQ-027 Latency: req high at edge N gives ACCESS for N+1..N+MEM_LATENCY, RESP/ack in cycle N+MEM_LATENCY+1, and rdata valid from edge N+MEM_LATENCY+1.
REQ-028 Back-to-back accesses SHALL be separated by at least one IDLE cycle; strobes SHALL be low in IDLE.
REQ-029 Requesters SHALL hold req and fields until ack; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-030 A req dropped mid-access SHALL NOT abort the access; ack SHALL still pulse.
REQ-031 mem_readM and mem_writeM SHALL never be high together; i_ack and d_ack SHALL never be high together.
REQ-032 rdata of the non-granted port SHALL hold its value; write accesses SHALL NOT change rdata.
REQ-033 Changes on i_address, d_address or wdata after the grant SHALL NOT affect mem_address or mem_wdata.

Reset
REQ-034 reset_n low SHALL immediately, without waiting for clk, force IDLE, all strobes, acks and busy to 0, mem_address, mem_wdata, i_rdata and d_rdata to 0, the counter to 0, and last_grant to data, so the instruction port wins the first tie.
REQ-035 Reset asserted during ACCESS or RESP SHALL abandon the access with no ack.
REQ-036 After reset release, the first edge with a req high SHALL start arbitration normally.

Verification
REQ-037 I-read, MEM_LATENCY=2: i_req with addr 0x0023, mem returns 0x6000 -> mem_readM high for 3 cycles, i_ack in the 3rd cycle after req, i_rdata=0x6000.
REQ-038 D-write: addr 0x00F0, data 0xBEEF -> mem_writeM high exactly 2 cycles with addr 0x00F0 and wdata 0xBEEF, then d_ack, no strobe in the ack cycle.
REQ-039 Simultaneous i_req and d_req held after reset -> I served first, then after one IDLE cycle D served; acks never overlap.
REQ-040 Both ports requesting continuously for 6 accesses -> grants alternate I,D,I,D,I,D.
REQ-041 reset_n dropped in the 2nd ACCESS cycle of a D-read -> strobes low immediately, no d_ack, busy=0; after release, a new i_req completes normally.
REQ-042 d_address changed from 0x10 to 0x20 one cycle after grant -> mem_address stays 0x10 through RESP.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of a single fixed-latency memory.
// Each grant latches its request, holds the memory strobe for MEM_LATENCY cycles, then acks for one cycle.
module mem_arbiter #(
   parameter int unsigned WORD_SIZE   = 16,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_req,
   input  logic                 i_write,
   input  logic [WORD_SIZE-1:0] i_address,
   input  logic [WORD_SIZE-1:0] i_wdata,
   output logic [WORD_SIZE-1:0] i_rdata,
   output logic                 i_ack,
   input  logic                 d_req,
   input  logic                 d_write,
   input  logic [WORD_SIZE-1:0] d_address,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 d_ack,
   output logic                 mem_readM,
   output logic                 mem_writeM,
   output logic [WORD_SIZE-1:0] mem_address,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   localparam logic [3:0] COUNT_LOAD = 4'(MEM_LATENCY - 1);

   state_t                state, state_next;
   logic [3:0]            count, count_next;
   // 0 = instruction port, 1 = data port; doubles as the current grant owner
   logic                  last_grant, last_grant_next;
   logic                  acc_write, acc_write_next;
   logic [WORD_SIZE-1:0]  acc_address, acc_address_next;
   logic [WORD_SIZE-1:0]  acc_wdata, acc_wdata_next;
   logic                  winner;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         count       <= '0;
         last_grant  <= 1'b1;
         acc_write   <= 1'b0;
         acc_address <= '0;
         acc_wdata   <= '0;
         i_rdata     <= '0;
         d_rdata     <= '0;
      end else begin
         state       <= state_next;
         count       <= count_next;
         last_grant  <= last_grant_next;
         acc_write   <= acc_write_next;
         acc_address <= acc_address_next;
         acc_wdata   <= acc_wdata_next;
         if (state == RESP && !acc_write) begin
            if (last_grant)
               d_rdata <= mem_rdata;
            else
               i_rdata <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_next       = state;
      count_next       = count;
      last_grant_next  = last_grant;
      acc_write_next   = acc_write;
      acc_address_next = acc_address;
      acc_wdata_next   = acc_wdata;
      winner           = 1'b0;

      mem_readM   = 1'b0;
      mem_writeM  = 1'b0;
      i_ack       = 1'b0;
      d_ack       = 1'b0;
      busy        = (state != IDLE);
      mem_address = acc_address;
      mem_wdata   = acc_wdata;

      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               // On a tie the port that did not win last time goes next
               winner           = (i_req && d_req) ? ~last_grant : d_req;
               last_grant_next  = winner;
               acc_write_next   = winner ? d_write   : i_write;
               acc_address_next = winner ? d_address : i_address;
               acc_wdata_next   = winner ? d_wdata   : i_wdata;
               count_next       = COUNT_LOAD;
               state_next       = ACCESS;
            end
         end
         ACCESS: begin
            mem_readM  = !acc_write;
            mem_writeM = acc_write;
            if (count == 4'd0)
               state_next = RESP;
            else
               count_next = count - 4'd1;
         end
         RESP: begin
            mem_readM  = !acc_write;
            i_ack      = !last_grant;
            d_ack      = last_grant;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued when driven and
// checked against strobes, acks and rdata as the arbiter completes them.
module tb_mem_arbiter;

   localparam int W = 16;
   localparam int L = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          i_req, i_write, d_req, d_write;
   logic [W-1:0]  i_address, i_wdata, d_address, d_wdata;
   logic [W-1:0]  i_rdata, d_rdata;
   logic          i_ack, d_ack;
   logic          mem_readM, mem_writeM, busy;
   logic [W-1:0]  mem_address, mem_wdata, mem_rdata;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit           port;
      bit           write;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
      logic [W-1:0] rdata;
   } txn_t;

   txn_t sb[$];

   // memory model: unwritten locations return a fixed pattern
   bit           written[256];
   logic [W-1:0] wmem[256];
   bit           sh_written[256];
   logic [W-1:0] sh_mem[256];

   function automatic logic [W-1:0] pattern(input logic [W-1:0] a);
      if (a == 16'h0023)
         return 16'h6000;
      return {a[7:0] ^ 8'h5A, a[7:0]};
   endfunction

   assign mem_rdata = written[mem_address[7:0]] ? wmem[mem_address[7:0]] : pattern(mem_address);

   always @(posedge clk) begin
      if (mem_writeM) begin
         written[mem_address[7:0]] <= 1'b1;
         wmem[mem_address[7:0]]    <= mem_wdata;
      end
   end

   always #5 clk = ~clk;

   mem_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(L)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   task automatic push(input bit port, input bit write, input logic [W-1:0] addr,
                       input logic [W-1:0] wdata);
      txn_t t;
      t.port  = port;
      t.write = write;
      t.addr  = addr;
      t.wdata = wdata;
      t.rdata = sh_written[addr[7:0]] ? sh_mem[addr[7:0]] : pattern(addr);
      if (write) begin
         sh_written[addr[7:0]] = 1'b1;
         sh_mem[addr[7:0]]     = wdata;
      end
      sb.push_back(t);
   endtask

   task automatic apply_reset();
      i_req = 1'b0;
      d_req = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Waits for the oldest queued transaction to complete and checks it against the bus.
   task automatic collect(input string name, input int exp_wait, input int exp_strobes,
                          input bit release_req);
      txn_t         e;
      int           n = 0;
      int           strobes = 0;
      bit           got = 0;
      logic [W-1:0] prev_i, prev_d, exp_i, exp_d;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: queue empty, required one entry", name);
         return;
      end
      e = sb.pop_front();
      prev_i = i_rdata;
      prev_d = d_rdata;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         checks++;
         if ((mem_readM && mem_writeM) || (i_ack && d_ack)) begin
            errors++;
            $display("FAIL %s exclusive: rd=%b wr=%b iack=%b dack=%b", name,
                     mem_readM, mem_writeM, i_ack, d_ack);
         end
         if (mem_readM || mem_writeM) begin
            strobes++;
            checks++;
            if (mem_writeM !== e.write || mem_readM !== !e.write || mem_address !== e.addr ||
                (e.write && mem_wdata !== e.wdata)) begin
               errors++;
               $display("FAIL %s bus: wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                        name, mem_writeM, mem_address, mem_wdata, e.write, e.addr, e.wdata);
            end
         end
         if (i_ack || d_ack) begin
            got = 1;
            checks++;
            if (d_ack !== e.port) begin
               errors++;
               $display("FAIL %s port: d_ack=%b, required %b", name, d_ack, e.port);
            end
            checks++;
            if (n !== exp_wait) begin
               errors++;
               $display("FAIL %s latency: ack after %0d cycles, required %0d", name, n, exp_wait);
            end
            checks++;
            if (mem_writeM !== 1'b0 || mem_readM !== !e.write) begin
               errors++;
               $display("FAIL %s resp strobes: rd=%b wr=%b, required rd=%b wr=0", name,
                        mem_readM, mem_writeM, !e.write);
            end
            if (release_req) begin
               if (e.port) d_req = 1'b0;
               else        i_req = 1'b0;
            end
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: no ack within %0d cycles, required %0d", name, n, exp_wait);
         return;
      end
      if (strobes !== exp_strobes) begin
         errors++;
         $display("FAIL %s strobe cycles: %0d, required %0d", name, strobes, exp_strobes);
      end
      @(negedge clk);
      exp_i = (!e.write && !e.port) ? e.rdata : prev_i;
      exp_d = (!e.write &&  e.port) ? e.rdata : prev_d;
      checks++;
      if (i_rdata !== exp_i || d_rdata !== exp_d) begin
         errors++;
         $display("FAIL %s rdata: i=%h d=%h, required i=%h d=%h", name, i_rdata, d_rdata,
                  exp_i, exp_d);
      end
      checks++;
      if (busy !== 1'b0 || mem_readM !== 1'b0 || mem_writeM !== 1'b0 || i_ack !== 1'b0 ||
          d_ack !== 1'b0) begin
         errors++;
         $display("FAIL %s idle gap: busy=%b rd=%b wr=%b iack=%b dack=%b, required all 0",
                  name, busy, mem_readM, mem_writeM, i_ack, d_ack);
      end
   endtask

   task automatic test_reset();
      i_req = 1'b0; i_write = 1'b0; i_address = '0; i_wdata = '0;
      d_req = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, mem_readM, mem_writeM, i_ack, d_ack} !== 5'b0 || mem_address !== '0 ||
          mem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
         errors++;
         $display("FAIL reset: busy=%b rd=%b wr=%b ia=%b da=%b addr=%h wd=%h ir=%h dr=%h, required 0",
                  busy, mem_readM, mem_writeM, i_ack, d_ack, mem_address, mem_wdata,
                  i_rdata, d_rdata);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset release busy: %b, required 0", busy);
      end
   endtask

   task automatic test_i_read();
      i_write = 1'b0; i_address = 16'h0023; i_req = 1'b1;
      push(1'b0, 1'b0, 16'h0023, '0);
      collect("i_read", L + 1, L + 1, 1'b1);
      checks++;
      if (i_rdata !== 16'h6000) begin
         errors++;
         $display("FAIL i_read value: %h, required 6000", i_rdata);
      end
   endtask

   task automatic test_d_write();
      d_write = 1'b1; d_address = 16'h00F0; d_wdata = 16'hBEEF; d_req = 1'b1;
      push(1'b1, 1'b1, 16'h00F0, 16'hBEEF);
      collect("d_write", L + 1, L, 1'b1);
      d_write = 1'b0; d_req = 1'b1;
      push(1'b1, 1'b0, 16'h00F0, '0);
      collect("d_readback", L + 1, L + 1, 1'b1);
   endtask

   task automatic test_tie_after_reset();
      apply_reset();
      i_write = 1'b0; i_address = 16'h0050;
      d_write = 1'b0; d_address = 16'h0051;
      i_req = 1'b1; d_req = 1'b1;
      push(1'b0, 1'b0, 16'h0050, '0);
      push(1'b1, 1'b0, 16'h0051, '0);
      collect("tie_first", L + 1, L + 1, 1'b1);
      collect("tie_second", L + 1, L + 1, 1'b1);
   endtask

   task automatic test_round_robin();
      logic [W-1:0] at[6];
      bit           wt[6];
      logic [W-1:0] dt[6];
      at[0] = 16'h0040; wt[0] = 0;
      at[1] = 16'h0041; wt[1] = 1;
      at[2] = 16'h0042; wt[2] = 0;
      at[3] = 16'h0041; wt[3] = 0;
      at[4] = 16'h0044; wt[4] = 1;
      at[5] = 16'h0044; wt[5] = 0;
      for (int k = 0; k < 6; k++) dt[k] = 16'($urandom);
      apply_reset();
      i_write = wt[0]; i_address = at[0]; i_wdata = dt[0];
      d_write = wt[1]; d_address = at[1]; d_wdata = dt[1];
      i_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         push(k[0], wt[k], at[k], dt[k]);
         collect($sformatf("rr%0d", k), L + 1, wt[k] ? L : L + 1, k >= 4);
         if (k + 2 < 6) begin
            if (k[0]) begin
               d_write = wt[k+2]; d_address = at[k+2]; d_wdata = dt[k+2];
            end else begin
               i_write = wt[k+2]; i_address = at[k+2]; i_wdata = dt[k+2];
            end
         end
      end
   endtask

   task automatic test_reset_mid_access();
      d_write = 1'b0; d_address = 16'h0060; d_req = 1'b1;
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (mem_readM !== 1'b0 || mem_writeM !== 1'b0 || busy !== 1'b0 || d_ack !== 1'b0 ||
          mem_address !== '0 || d_rdata !== '0) begin
         errors++;
         $display("FAIL mid reset: rd=%b wr=%b busy=%b dack=%b addr=%h drd=%h, required 0",
                  mem_readM, mem_writeM, busy, d_ack, mem_address, d_rdata);
      end
      d_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (d_ack !== 1'b0 || i_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid reset ack: dack=%b iack=%b, required 0", d_ack, i_ack);
         end
      end
      reset_n = 1'b1;
      @(negedge clk);
      i_write = 1'b0; i_address = 16'h0061; i_req = 1'b1;
      push(1'b0, 1'b0, 16'h0061, '0);
      collect("after_reset", L + 1, L + 1, 1'b1);
   endtask

   task automatic test_addr_hold();
      d_write = 1'b0; d_address = 16'h0010; d_req = 1'b1;
      push(1'b1, 1'b0, 16'h0010, '0);
      @(negedge clk);
      checks++;
      if (mem_readM !== 1'b1 || mem_address !== 16'h0010) begin
         errors++;
         $display("FAIL addr_hold grant: rd=%b addr=%h, required rd=1 addr=0010",
                  mem_readM, mem_address);
      end
      d_address = 16'h0020;
      d_wdata   = 16'h1234;
      collect("addr_hold", L, L, 1'b1);
   endtask

   initial begin
      test_reset();
      test_i_read();
      test_d_write();
      test_tie_after_reset();
      test_round_robin();
      test_reset_mid_access();
      test_addr_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
